// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states, requester ids, return-pipe entry.
// Also holds the block-offset width helper used to slice beat addresses.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } req_t;

    typedef struct packed {
        logic vld;
        logic last;
        req_t owner;
    } rsp_t;

    // Byte-offset bits of one cache block: word-index bits plus the 2 byte bits.
    function automatic int off_w(input int burst_len);
        return $clog2(burst_len) + 2;
    endfunction

endpackage

// File: rtl/mem_arb_rsp_pipe.sv
// Purpose: tracks in-flight memory reads so each return is tagged with owner and last flag.
// Latency: MEM_LAT cycles from entry to exit; one entry per cycle.
// Backpressure: none; memory returns cannot be stalled, clr discards everything in flight.
module mem_arb_rsp_pipe
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic clr,
    input  rsp_t in_rsp,
    output rsp_t out_rsp
);

    rsp_t stage [MEM_LAT];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= in_rsp;
            for (int i = 1; i < MEM_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out_rsp = stage[MEM_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: shares one fixed-latency memory between I-cache refills and D-cache read/write bursts.
// Latency: grant and beat 0 one cycle after req is seen in IDLE; read data MEM_LAT after each issue.
// Backpressure: requests wait in IDLE only; a granted burst always runs to completion.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie-breaking (default: D side wins ties).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4,
    parameter int MEM_LAT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_last,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_wready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_last,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int OFF = off_w(BURST_LEN);
    localparam int BW  = OFF - 2;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    arb_state_t          state;
    req_t                cur_owner;
    logic [ADDR_W-OFF-1:0] base;
    logic [BW-1:0]       beat;
    logic                issue;
    logic                we_q;
    logic                i_gnt_q;
    logic                d_gnt_q;
    logic                pick_d;
    rsp_t                pipe_in;
    rsp_t                pipe_out;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{i_addr[OFF-1:0], d_addr[OFF-1:0]};

`ifdef MEM_ARB_RR_EN
    req_t last_srv;

    // On a tie the side that was not served most recently wins.
    always_comb begin
        pick_d = d_req & (~i_req | (last_srv == REQ_I));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_srv <= REQ_I;
        end else if (state == IDLE && (i_req || d_req)) begin
            last_srv <= pick_d ? REQ_D : REQ_I;
        end
    end
`else
    always_comb begin
        pick_d = d_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_owner <= REQ_I;
            base      <= '0;
            beat      <= '0;
            issue     <= 1'b0;
            we_q      <= 1'b0;
            i_gnt_q   <= 1'b0;
            d_gnt_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        cur_owner <= pick_d ? REQ_D : REQ_I;
                        base      <= pick_d ? d_addr[ADDR_W-1:OFF] : i_addr[ADDR_W-1:OFF];
                        beat      <= '0;
                        issue     <= 1'b1;
                        we_q      <= pick_d & d_we;
                        state     <= (pick_d && d_we) ? WR : RD;
                        i_gnt_q   <= ~pick_d;
                        d_gnt_q   <= pick_d;
                    end
                end
                RD: begin
                    if (issue) begin
                        beat <= beat + BW'(1);
                        if (beat == LAST_BEAT) begin
                            issue <= 1'b0;
                        end
                    end
                    // Grant is held until the final return has been delivered.
                    if (pipe_out.vld && pipe_out.last) begin
                        state   <= IDLE;
                        i_gnt_q <= 1'b0;
                        d_gnt_q <= 1'b0;
                    end
                end
                WR: begin
                    beat <= beat + BW'(1);
                    if (beat == LAST_BEAT) begin
                        issue   <= 1'b0;
                        we_q    <= 1'b0;
                        state   <= IDLE;
                        i_gnt_q <= 1'b0;
                        d_gnt_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign pipe_in = '{vld: issue & ~we_q, last: (beat == LAST_BEAT), owner: cur_owner};

    mem_arb_rsp_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_rsp_pipe (
        .clk     (clk),
        .clr     (!rst_n),
        .in_rsp  (pipe_in),
        .out_rsp (pipe_out)
    );

    assign mem_en    = issue;
    assign mem_we    = we_q;
    assign mem_addr  = {base, beat, 2'b00};
    assign mem_wdata = we_q ? d_wdata : '0;
    assign d_wready  = we_q;

    assign i_gnt    = i_gnt_q;
    assign d_gnt    = d_gnt_q;
    assign i_rvalid = pipe_out.vld & (pipe_out.owner == REQ_I);
    assign d_rvalid = pipe_out.vld & (pipe_out.owner == REQ_D);
    assign i_rdata  = i_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;
    assign i_last   = i_rvalid & pipe_out.last;
    assign d_last   = (d_rvalid & pipe_out.last) | (we_q & (beat == LAST_BEAT));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with BURST_LEN=4, MEM_LAT=2 and a memory that returns the address as data.
module tb_mem_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 4;
    localparam int MEM_LAT   = 2;
    localparam logic [31:0] BLK_MASK = ~32'(BURST_LEN * 4 - 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_gnt, i_rvalid, i_last;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_gnt, d_wready, d_rvalid, d_last;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    typedef struct packed {
        logic        we;
        logic        wlast;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_op_t;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } ret_t;

    mem_op_t exp_mem[$];
    ret_t    exp_i[$];
    ret_t    exp_d[$];
    int      errors = 0;
    int      checks = 0;
    bit      mon_on = 1'b0;
    logic [DATA_W-1:0] rd_pipe [MEM_LAT] = '{default: '0};

    mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_last(i_last),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_wready(d_wready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_last(d_last),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Fixed-latency memory: read data appears MEM_LAT cycles after the read issue.
    always @(posedge clk) begin
        rd_pipe[0] <= (mem_en && !mem_we) ? mem_addr : 32'h0;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    // Scoreboard: every memory op and every return is matched against the expectation queues.
    always @(negedge clk) begin : mon
        mem_op_t m;
        ret_t    r;
        if (mon_on) begin
            if (mem_en) begin
                checks++;
                if (exp_mem.size() == 0) begin
                    errors++;
                    $display("FAIL mem_op_unexpected: got we=%0b addr=%h, expected no op", mem_we, mem_addr);
                end else begin
                    m = exp_mem.pop_front();
                    if (mem_we !== m.we || mem_addr !== m.addr ||
                        (m.we && (mem_wdata !== m.wdata || d_wready !== 1'b1 || d_last !== m.wlast)) ||
                        (!m.we && d_wready !== 1'b0)) begin
                        errors++;
                        $display("FAIL mem_op: got we=%0b addr=%h wdata=%h wready=%0b dlast=%0b, expected we=%0b addr=%h wdata=%h wlast=%0b",
                                 mem_we, mem_addr, mem_wdata, d_wready, d_last, m.we, m.addr, m.wdata, m.wlast);
                    end
                end
            end
            if (i_rvalid) begin
                checks++;
                if (exp_i.size() == 0) begin
                    errors++;
                    $display("FAIL i_ret_unexpected: got data=%h last=%0b, expected none", i_rdata, i_last);
                end else begin
                    r = exp_i.pop_front();
                    if (i_rdata !== r.data || i_last !== r.last || d_rvalid !== 1'b0 || d_rdata !== '0) begin
                        errors++;
                        $display("FAIL i_ret: got data=%h last=%0b d_rvalid=%0b d_rdata=%h, expected data=%h last=%0b d side 0",
                                 i_rdata, i_last, d_rvalid, d_rdata, r.data, r.last);
                    end
                end
            end
            if (d_rvalid) begin
                checks++;
                if (exp_d.size() == 0) begin
                    errors++;
                    $display("FAIL d_ret_unexpected: got data=%h last=%0b, expected none", d_rdata, d_last);
                end else begin
                    r = exp_d.pop_front();
                    if (d_rdata !== r.data || d_last !== r.last || i_rvalid !== 1'b0 || i_rdata !== '0) begin
                        errors++;
                        $display("FAIL d_ret: got data=%h last=%0b i_rvalid=%0b i_rdata=%h, expected data=%h last=%0b i side 0",
                                 d_rdata, d_last, i_rvalid, i_rdata, r.data, r.last);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input bit d_side, input logic [31:0] addr);
        logic [31:0] blk = addr & BLK_MASK;
        for (int k = 0; k < BURST_LEN; k++) begin
            exp_mem.push_back('{we: 1'b0, wlast: 1'b0, addr: blk + 32'(4 * k), wdata: 32'h0});
            if (d_side) exp_d.push_back('{last: (k == BURST_LEN - 1), data: blk + 32'(4 * k)});
            else        exp_i.push_back('{last: (k == BURST_LEN - 1), data: blk + 32'(4 * k)});
        end
    endtask

    task automatic push_wr(input logic [31:0] addr, input logic [31:0] dbase);
        logic [31:0] blk = addr & BLK_MASK;
        for (int k = 0; k < BURST_LEN; k++) begin
            exp_mem.push_back('{we: 1'b1, wlast: (k == BURST_LEN - 1), addr: blk + 32'(4 * k),
                                wdata: dbase + 32'(k)});
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if ({i_gnt, i_rvalid, i_last, d_gnt, d_wready, d_rvalid, d_last, mem_en, mem_we} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, expected all 0",
                     {i_gnt, i_rvalid, i_last, d_gnt, d_wready, d_rvalid, d_last, mem_en, mem_we});
        end
        checks++;
        if ({i_rdata, d_rdata, mem_addr, mem_wdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got i=%h d=%h addr=%h wdata=%h, expected 0", i_rdata, d_rdata, mem_addr, mem_wdata);
        end
        tick();
        rst_n = 1'b1;
        mon_on = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if ({mem_en, i_gnt, d_gnt} !== 3'b0) begin
            errors++;
            $display("FAIL idle_no_req: got en/ig/dg=%b, expected 000", {mem_en, i_gnt, d_gnt});
        end
        tick();
    endtask

    task automatic test_i_read;
        int first_en = -1, last_en = -1, first_rv = -1, last_cyc = -1, drop = -1, gcnt = 0;
        push_rd(1'b0, 32'h104);
        i_addr = 32'h104;
        i_req  = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (mem_en && first_en < 0) first_en = k;
            if (mem_en) last_en = k;
            if (i_rvalid && first_rv < 0) first_rv = k;
            if (i_gnt) gcnt++;
            if (!i_gnt && first_en >= 0 && drop < 0) drop = k;
            if (i_last) begin last_cyc = k; i_req = 1'b0; end
            tick();
        end
        checks++; if (first_en !== 1) begin errors++; $display("FAIL i_rd_first_issue: cycle %0d, expected 1", first_en); end
        checks++; if (last_en !== 4) begin errors++; $display("FAIL i_rd_last_issue: cycle %0d, expected 4", last_en); end
        checks++; if (first_rv !== 3) begin errors++; $display("FAIL i_rd_first_ret: cycle %0d, expected 3", first_rv); end
        checks++; if (last_cyc !== 6) begin errors++; $display("FAIL i_rd_last: cycle %0d, expected 6", last_cyc); end
        checks++; if (drop !== 7) begin errors++; $display("FAIL i_rd_gnt_drop: cycle %0d, expected 7", drop); end
        checks++; if (gcnt !== 6) begin errors++; $display("FAIL i_rd_gnt_len: %0d cycles, expected 6", gcnt); end
        checks++;
        if (exp_mem.size() != 0 || exp_i.size() != 0) begin
            errors++; $display("FAIL i_rd_drain: mem=%0d ret=%0d left, expected 0", exp_mem.size(), exp_i.size());
        end
    endtask

    task automatic test_d_write;
        int first_en = -1, wcnt = 0, dlast = -1, drop = -1, wb = 0;
        bit took;
        push_wr(32'h420, 32'hA5A5_0000);
        d_addr  = 32'h420;
        d_we    = 1'b1;
        d_wdata = 32'hA5A5_0000;
        d_req   = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            took = d_wready;
            if (mem_en && first_en < 0) first_en = k;
            if (mem_en && mem_we) wcnt++;
            if (!d_gnt && first_en >= 0 && drop < 0) drop = k;
            if (d_last) begin dlast = k; d_req = 1'b0; d_we = 1'b0; end
            tick();
            if (took) begin wb++; d_wdata = 32'hA5A5_0000 + 32'(wb); end
        end
        d_wdata = '0;
        checks++; if (first_en !== 1) begin errors++; $display("FAIL d_wr_first_issue: cycle %0d, expected 1", first_en); end
        checks++; if (wcnt !== 4) begin errors++; $display("FAIL d_wr_beats: %0d writes, expected 4", wcnt); end
        checks++; if (dlast !== 4) begin errors++; $display("FAIL d_wr_last: cycle %0d, expected 4", dlast); end
        checks++; if (drop !== 5) begin errors++; $display("FAIL d_wr_gnt_drop: cycle %0d, expected 5", drop); end
        checks++;
        if (exp_mem.size() != 0) begin errors++; $display("FAIL d_wr_drain: %0d ops left, expected 0", exp_mem.size()); end
    endtask

    task automatic test_priority;
        logic [2:0] want_seq;
        logic [2:0] seq = '0;
        int ngrant = 0, nlast = 0, done_k = -1;
        bit prev_i = 1'b0, prev_d = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
`ifdef MEM_ARB_RR_EN
        want_seq = 3'b101;
`else
        want_seq = 3'b111;
`endif
        for (int b = 0; b < 3; b++) push_rd(want_seq[b], want_seq[b] ? 32'h200 : 32'h300);
        d_addr = 32'h200;
        d_we   = 1'b0;
        i_addr = 32'h300;
        i_req  = 1'b1;
        d_req  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((i_gnt && !prev_i) || (d_gnt && !prev_d)) begin
                if (ngrant < 3) seq[ngrant] = d_gnt;
                ngrant++;
            end
            prev_i = i_gnt;
            prev_d = d_gnt;
            if (i_last || d_last) nlast++;
            if (nlast == 3 && done_k < 0) begin done_k = k; i_req = 1'b0; d_req = 1'b0; end
            if (done_k >= 0 && k >= done_k + 3) break;
            tick();
        end
        tick();
        checks++; if (ngrant !== 3) begin errors++; $display("FAIL prio_grants: %0d grants, expected 3", ngrant); end
        checks++; if (seq !== want_seq) begin errors++; $display("FAIL prio_order: got %b (1=D, burst0 lsb), expected %b", seq, want_seq); end
        checks++;
        if (exp_mem.size() != 0 || exp_i.size() != 0 || exp_d.size() != 0) begin
            errors++; $display("FAIL prio_drain: mem=%0d i=%0d d=%0d left, expected 0", exp_mem.size(), exp_i.size(), exp_d.size());
        end
    endtask

    task automatic test_drop_req;
        int rv = 0, dlast = -1, drop = -1;
        bit started = 1'b0;
        push_rd(1'b1, 32'h510);
        d_addr = 32'h510;
        d_we   = 1'b0;
        d_req  = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (d_gnt) started = 1'b1;
            if (d_rvalid) rv++;
            if (d_last) dlast = k;
            if (!d_gnt && started && drop < 0) drop = k;
            if (k == 2) d_req = 1'b0;
            tick();
        end
        checks++; if (rv !== 4) begin errors++; $display("FAIL drop_rvalid: %0d returns, expected 4", rv); end
        checks++; if (dlast !== 6) begin errors++; $display("FAIL drop_last: cycle %0d, expected 6", dlast); end
        checks++; if (drop !== 7) begin errors++; $display("FAIL drop_gnt: cycle %0d, expected 7", drop); end
        checks++;
        if (exp_mem.size() != 0 || exp_d.size() != 0) begin
            errors++; $display("FAIL drop_drain: mem=%0d d=%0d left, expected 0", exp_mem.size(), exp_d.size());
        end
    endtask

    task automatic test_reset_abort;
        int rv = 0, bad = 0, first_en = -1, ilast = -1;
        push_rd(1'b0, 32'h700);
        void'(exp_i.pop_back());
        void'(exp_i.pop_back());
        i_addr = 32'h700;
        i_req  = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (k < 5 && i_rvalid) rv++;
            if (k >= 5 && {i_gnt, mem_en, i_rvalid, i_last, d_gnt, d_rvalid} !== 6'b0) bad++;
            tick();
            if (k == 3) begin rst_n = 1'b0; i_req = 1'b0; end
            if (k == 4) rst_n = 1'b1;
        end
        checks++; if (rv !== 2) begin errors++; $display("FAIL abort_pre_returns: %0d, expected 2", rv); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL abort_quiet: %0d active cycles after reset, expected 0", bad); end
        checks++;
        if (exp_mem.size() != 0 || exp_i.size() != 0) begin
            errors++; $display("FAIL abort_drain: mem=%0d i=%0d left, expected 0", exp_mem.size(), exp_i.size());
        end
        push_rd(1'b0, 32'h700);
        i_req = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (mem_en && first_en < 0) first_en = k;
            if (i_last) begin ilast = k; i_req = 1'b0; end
            tick();
        end
        checks++; if (first_en !== 1) begin errors++; $display("FAIL abort_restart_issue: cycle %0d, expected 1", first_en); end
        checks++; if (ilast !== 6) begin errors++; $display("FAIL abort_restart_last: cycle %0d, expected 6", ilast); end
        checks++;
        if (exp_mem.size() != 0 || exp_i.size() != 0) begin
            errors++; $display("FAIL abort_restart_drain: mem=%0d i=%0d left, expected 0", exp_mem.size(), exp_i.size());
        end
    endtask

    task automatic test_back_to_back;
        int nlast = 0, l1 = -1, n2 = -1;
        push_rd(1'b0, 32'h800);
        push_rd(1'b0, 32'h800);
        i_addr = 32'h800;
        i_req  = 1'b1;
        for (int k = 0; k <= 25; k++) begin
            @(negedge clk);
            if (mem_en && nlast == 1 && n2 < 0) n2 = k;
            if (i_last) begin
                nlast++;
                if (nlast == 1) l1 = k;
                if (nlast == 2) i_req = 1'b0;
            end
            tick();
        end
        checks++; if (nlast !== 2) begin errors++; $display("FAIL b2b_bursts: %0d, expected 2", nlast); end
        checks++; if (n2 - l1 !== 2) begin errors++; $display("FAIL b2b_gap: next issue %0d cycles after last, expected 2", n2 - l1); end
        checks++;
        if (exp_mem.size() != 0 || exp_i.size() != 0) begin
            errors++; $display("FAIL b2b_drain: mem=%0d i=%0d left, expected 0", exp_mem.size(), exp_i.size());
        end
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_priority();
        test_drop_req();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
